// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters
// Optional UART_TX_SCHED_PRIO_EN: requester 0 has strict priority over the round-robin ring.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (FRAME_CYCLES > 0) ? $clog2(FRAME_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT   = CW'(FRAME_CYCLES);
    localparam logic [GW:0]   NREQ       = (GW + 1)'(NUM_REQ);
    localparam logic [GW-1:0] GRANT_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {STARTUP, IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] counter, counter_next;
    logic [1:0]    rst_sync;
    logic          found;
    logic [GW-1:0] winner;
    logic [GW:0]   cand_sum;
    logic [GW-1:0] cand;

    // Reset release reaches the startup counter only after two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Ring search begins one past the last grant and wraps modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = grant_id;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, grant_id} + (GW + 1)'(k);
            if (cand_sum >= NREQ) begin
                cand_sum = cand_sum - NREQ;
            end
            cand = cand_sum[GW-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef UART_TX_SCHED_PRIO_EN
        if (req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`else
`endif
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        req_ready    = '0;
        case (state)
            STARTUP: begin
                if (rst_sync[1]) begin
                    if (counter == '0) begin
                        state_next = IDLE;
                    end else begin
                        counter_next = counter - CW'(1);
                    end
                end
            end
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                counter_next = CNT_INIT;
                state_next   = (FRAME_CYCLES == 0) ? IDLE : WAIT;
            end
            WAIT: begin
                // FRAME_CYCLES wait cycles, so sends land FRAME_CYCLES+2 apart.
                counter_next = counter - CW'(1);
                if (counter <= CW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STARTUP;
            counter  <= CNT_INIT;
            tx_data  <= '0;
            grant_id <= GRANT_INIT;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (state == IDLE && found) begin
                tx_data  <= req_data[{winner, 3'b000} +: 8];
                grant_id <= winner;
            end
        end
    end

    assign tx_send = (state == ISSUE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int F = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_send;
    logic [7:0]     tx_data;
    logic           busy;
    logic [1:0]     grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .FRAME_CYCLES(F)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        if (v == '0) return -1;
`ifdef UART_TX_SCHED_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks += 5;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b exp 0", tx_send); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        if (grant_id !== 2'(N - 1)) begin errors++; $display("FAIL reset_grant_id got %0d exp %0d", grant_id, N - 1); end
    endtask

    task automatic test_first_grant;
        int cyc = 0;
        bit seen = 0;
        bit early = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b0001;
        req_data[7:0] = 8'hA5;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (tx_send) early = 1;
            if (req_ready != '0) seen = 1;
        end
        checks += 4;
        if (!seen) begin errors++; $display("FAIL first_ready_timeout got none exp pulse"); end
        if (early) begin errors++; $display("FAIL first_early_send got 1 exp 0"); end
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_ready got %b exp 0001", req_ready); end
        if (cyc < F + 2) begin errors++; $display("FAIL first_startup_len got %0d exp >=%0d", cyc, F + 2); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks += 4;
        if (tx_send !== 1'b1) begin errors++; $display("FAIL first_send got %b exp 1", tx_send); end
        if (tx_data !== 8'hA5) begin errors++; $display("FAIL first_data got %h exp a5", tx_data); end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL first_grant got %0d exp 0", grant_id); end
        if (req_ready !== '0) begin errors++; $display("FAIL first_ready_after got %b exp 0", req_ready); end
    endtask

    task automatic test_round_robin;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int cyc = 0;
        int last_t = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        while (n < 5 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (tx_send) begin
                checks += 2;
                if (grant_id !== 2'(exp_g[n])) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", n, grant_id, exp_g[n]); end
                if (tx_data !== 8'(8'h10 + exp_g[n])) begin errors++; $display("FAIL rr_data%0d got %h exp %h", n, tx_data, 8'h10 + exp_g[n]); end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_t != F + 2) begin errors++; $display("FAIL rr_spacing%0d got %0d exp %0d", n, cyc - last_t, F + 2); end
                end
                last_t = cyc;
                n++;
            end
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL rr_timeout got %0d sends exp 5", n); end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

`ifdef UART_TX_SCHED_PRIO_EN
    task automatic test_priority;
        int n = 0;
        int cyc = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b0011;
        req_data[15:0] = 16'h2120;
        while (n < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (tx_send) begin
                checks++;
                if (grant_id !== ((n < 3) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL prio_grant%0d got %0d exp %0d", n, grant_id, (n < 3) ? 0 : 1); end
                n++;
                if (n == 3) begin @(posedge clk); #1; req_valid[0] = 1'b0; end
            end
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL prio_timeout got %0d sends exp 4", n); end
        @(posedge clk); #1;
        req_valid = '0;
    endtask
`endif

    task automatic test_wait_request;
        bit early = 0;
        bit seen = 0;
        int cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b0100;
        req_data[23:16] = 8'h5C;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                if (req_ready !== '0) early = 1;
            end else begin
                seen = 1;
            end
        end
        checks += 3;
        if (early) begin errors++; $display("FAIL wait_early_ready got 1 exp 0"); end
        if (!seen) begin errors++; $display("FAIL wait_idle_timeout got busy exp idle"); end
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL wait_ready got %b exp 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks += 3;
        if (tx_send !== 1'b1) begin errors++; $display("FAIL wait_send got %b exp 1", tx_send); end
        if (tx_data !== 8'h5C) begin errors++; $display("FAIL wait_data got %h exp 5c", tx_data); end
        if (grant_id !== 2'd2) begin errors++; $display("FAIL wait_grant got %0d exp 2", grant_id); end
    endtask

    task automatic test_reset_mid_frame;
        int cyc = 0;
        bit done = 0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
        if (tx_send !== 1'b0) begin errors++; $display("FAIL midrst_send got %b exp 0", tx_send); end
        if (req_ready !== '0) begin errors++; $display("FAIL midrst_ready got %b exp 0", req_ready); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", tx_data); end
        if (grant_id !== 2'(N - 1)) begin errors++; $display("FAIL midrst_grant got %0d exp %0d", grant_id, N - 1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b0010;
        req_data[15:8] = 8'h3C;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (tx_send) begin
                done = 1;
            end else if (req_ready != '0) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
        end
        checks += 4;
        if (!done) begin errors++; $display("FAIL midrst_timeout got none exp send"); end
        if (cyc < F + 2) begin errors++; $display("FAIL midrst_gap got %0d exp >=%0d", cyc, F + 2); end
        if (tx_data !== 8'h3C) begin errors++; $display("FAIL midrst_data2 got %h exp 3c", tx_data); end
        if (grant_id !== 2'd1) begin errors++; $display("FAIL midrst_grant2 got %0d exp 1", grant_id); end
    endtask

    // Entered on the negedge of a send by requester 1; the model tracks
    // cycles since the last send and treats the scheduler as free after F+1.
    task automatic test_random;
        logic [7:0]   acc_q[$];
        logic [7:0]   ser_q[$];
        logic [N-1:0] handshook = '0;
        logic [N-1:0] exp_ready;
        logic [7:0]   pend_byte = 8'h3C;
        int  since = 0;
        int  last = 1;
        int  uart_cnt = F;
        int  w;
        bit  exp_send = 0;
        bit  idle;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (handshook[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 99) < 25) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            if (exp_send) since = 0; else since++;
            idle = !exp_send && since >= F + 1;
            w = idle ? rr_pick(req_valid, last) : -1;
            exp_ready = (w >= 0) ? (N'(1) << w) : '0;
            checks += 3;
            if (tx_send !== exp_send) begin errors++; $display("FAIL rnd_send c%0d got %b exp %b", c, tx_send, exp_send); end
            if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_ready); end
            if (busy !== !idle) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, !idle); end
            if (exp_send) begin
                checks += 2;
                if (tx_data !== pend_byte) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, tx_data, pend_byte); end
                if (grant_id !== 2'(last)) begin errors++; $display("FAIL rnd_grant c%0d got %0d exp %0d", c, grant_id, last); end
            end
            if (tx_send) begin
                checks++;
                if (uart_cnt != 0) begin errors++; $display("FAIL uart_overlap c%0d got busy %0d exp 0", c, uart_cnt); end
                ser_q.push_back(tx_data);
                uart_cnt = F;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
            end
            exp_send = (w >= 0);
            handshook = exp_ready;
            if (w >= 0) begin
                last = w;
                pend_byte = req_data[8*w +: 8];
                acc_q.push_back(pend_byte);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (F + 4) @(negedge clk);
        if (exp_send) ser_q.push_back(pend_byte);
        checks += 2;
        if (acc_q.size() < 20) begin errors++; $display("FAIL rnd_activity got %0d exp >=20", acc_q.size()); end
        if (ser_q.size() != acc_q.size()) begin errors++; $display("FAIL sb_count got %0d exp %0d", ser_q.size(), acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < ser_q.size(); i++) begin
            checks++;
            if (ser_q[i] !== acc_q[i]) begin errors++; $display("FAIL sb_byte%0d got %h exp %h", i, ser_q[i], acc_q[i]); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_grant();
`ifdef UART_TX_SCHED_PRIO_EN
        test_priority();
`else
        test_round_robin();
`endif
        test_wait_request();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter FRAME_CYCLES, default 10, cycles uart_tx needs after a load before it accepts the next send.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester byte pending.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept pulse; byte i taken when req_valid[i] and req_ready[i] are both high.
REQ-008 tx_send  output  1  one-cycle load strobe to uart_tx send.
REQ-009 tx_data  output  8  byte to uart_tx data_in.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the last accepted requester.

Function
REQ-012 FSM states SHALL be STARTUP, IDLE, ISSUE and WAIT.
REQ-013 STARTUP: down-counter runs from FRAME_CYCLES to 0; at 0 go to IDLE; no grants are issued.
REQ-014 IDLE: if any req_valid, pick winner i, pulse req_ready[i] for exactly one cycle, register req_data[i] into tx_data, set grant_id=i, go to ISSUE; else stay.
REQ-015 ISSUE: tx_send=1 for exactly one cycle with tx_data stable; load counter with FRAME_CYCLES; go to WAIT.
REQ-016 WAIT: decrement counter each cycle; at 0 go to IDLE; tx_data held unchanged throughout.
REQ-017 Winner selection: round-robin starting at (grant_id+1) mod NUM_REQ, wrapping past NUM_REQ-1 to 0.
REQ-018 Consecutive tx_send pulses SHALL be at least FRAME_CYCLES+2 cycles apart.
REQ-019 Latency: from req_valid sampled high in IDLE to tx_send high is 1 cycle.
REQ-020 req_ready SHALL be zero in all states except the IDLE accept cycle, and at most one bit is set.
REQ-021 req_valid dropping without a handshake SHALL NOT be granted; requests arriving in ISSUE or WAIT wait until IDLE.
REQ-022 If all requesters are valid continuously, each SHALL be served once per NUM_REQ grants.
REQ-023 FRAME_CYCLES=0 SHALL still give a 2-cycle gap between send pulses.

Reset
REQ-024 rst_n low SHALL asynchronously force: state STARTUP, req_ready=0, tx_send=0, tx_data=0, busy=1, grant_id=NUM_REQ-1, counter=FRAME_CYCLES.
REQ-025 Reset mid-frame SHALL drop the in-flight grant; uart_tx has no reset, so STARTUP covers its remaining frame before the first new send.
REQ-026 Reset release SHALL be synchronised with two flops before STARTUP starts counting.
REQ-027 First grant after reset SHALL go to requester 0 if it is valid.

Configuration
REQ-028 Macro UART_TX_SCHED_PRIO_EN: when defined, requester 0 SHALL win over all others whenever its req_valid is high in IDLE; the rest use round-robin among themselves.
REQ-029 Without UART_TX_SCHED_PRIO_EN, pure round-robin per REQ-017 SHALL apply, with no extra logic.

Verification
REQ-030 Reset then req_valid[0]=1 with data 0xA5 -> no send before STARTUP completes; then req_ready[0] pulse, next cycle tx_send=1, tx_data=0xA5, grant_id=0.
REQ-031 All four valid continuously with data 0x10..0x13 -> grants 0,1,2,3,0; tx_send spacing exactly 12 cycles with FRAME_CYCLES=10.
REQ-032 req_valid[2] asserted during WAIT -> no req_ready until IDLE, then grant 2 in the first IDLE cycle.
REQ-033 rst_n low during WAIT -> outputs at reset values within the same cycle; after release no tx_send for at least FRAME_CYCLES+2 cycles.
REQ-034 With UART_TX_SCHED_PRIO_EN, requesters 0 and 1 valid continuously -> only requester 0 granted; drop req_valid[0] -> requester 1 granted next.
REQ-035 Scoreboard with a uart_tx model -> serial bytes on tx match accepted bytes in order; tx_send never occurs while the uart_tx model is mid-frame.
